// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: alignment/legality checks, byte-lane formatting, req/gnt/rvalid sequencing.
// Build option LSU_TIMEOUT_EN adds a bus-timeout abort that raises fault_bus.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_idx,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        rd_we,
    output logic        fault_misalign,
    output logic        fault_illegal,
    output logic        fault_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state_dbg
);

    // Handshake: mem_req acts as valid and mem_gnt as ready; the request (addr/we/wstrb/wdata)
    // stays stable while mem_req is high and transfers on the edge where both are high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    state_t      state, state_nxt;
    logic        load_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        in_load, in_store, in_illegal, in_misalign;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_fmt;
    logic        fin;
    logic        timeout;

    always_comb begin
        in_load     = (opcode == OP_L);
        in_store    = (opcode == OP_S);
        in_illegal  = 1'b1;
        if (in_load)
            in_illegal = !(func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (in_store)
            in_illegal = !(func3 inside {3'b000, 3'b001, 3'b010});
        in_misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                      ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (func3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_strb  = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_strb  = 4'b0011 << addr[1:0];
            end
            default: begin
                st_wdata = store_data;
                st_strb  = 4'b1111;
            end
        endcase
    end

    // Halfwords are always aligned by the time data returns, so off_q[1] picks the half.
    always_comb begin
        case (off_q)
            2'd0:    ld_b = mem_rdata[7:0];
            2'd1:    ld_b = mem_rdata[15:8];
            2'd2:    ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase
        ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_fmt = {24'd0, ld_b};
            3'b101:  ld_fmt = {16'd0, ld_h};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (in_illegal || in_misalign) state_nxt = DONE;
                    else                           state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (load_q) state_nxt = WAIT_R;
                    else        state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = DONE;
                end
            end
            WAIT_R: begin
                if (mem_rvalid || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign fin       = (state != DONE) && (state_nxt == DONE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_req   = (state == REQ);
    assign rd_we     = done && load_q && !fault_misalign && !fault_illegal && !fault_bus;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_q         <= 1'b0;
            func3_q        <= 3'd0;
            off_q          <= 2'd0;
            rd_q           <= 5'd0;
            mem_addr       <= 32'd0;
            mem_we         <= 1'b0;
            mem_wstrb      <= 4'd0;
            mem_wdata      <= 32'd0;
            load_data      <= 32'd0;
            rd_out         <= 5'd0;
            fault_illegal  <= 1'b0;
            fault_misalign <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                load_q    <= in_load;
                func3_q   <= func3;
                off_q     <= addr[1:0];
                rd_q      <= rd_idx;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_we    <= in_store;
                mem_wstrb <= in_store ? st_strb : 4'd0;
                mem_wdata <= in_store ? st_wdata : 32'd0;
            end
            // Completion results change only on the edge into DONE and then hold.
            if (fin) begin
                fault_illegal  <= (state == IDLE) && in_illegal;
                fault_misalign <= (state == IDLE) && !in_illegal;
                rd_out         <= (state == IDLE) ? rd_idx : rd_q;
                load_data      <= (state == WAIT_R && mem_rvalid) ? ld_fmt : 32'd0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                               wait_cnt <= '0;
        else if (state_nxt != state)              wait_cnt <= '0;
        else if (state == REQ || state == WAIT_R) wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == REQ || state == WAIT_R) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // A grant or response arriving on the final cycle still wins over the abort.
    always_ff @(posedge clk) begin
        if (!rst_n)
            fault_bus <= 1'b0;
        else if (fin)
            fault_bus <= timeout && !((state == REQ && mem_gnt) || (state == WAIT_R && mem_rvalid));
    end
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign fault_bus          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
